// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the RAM read/write address controllers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    // Output buffer must hold every word that can be in the RAM pipeline
    // plus enough slack to keep one word per cycle flowing.
    function automatic int unsigned buf_depth(input int unsigned rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/mem_rd_ctrl_if.sv
// Control, RAM read port and output stream of the read-back controller.
interface mem_rd_ctrl_if #(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned DWIDTH = 8
);
    logic              start_i;
    logic              abort_i;
    logic [AWIDTH:0]   len_i;
    logic              rden_o;
    logic [AWIDTH-1:0] rdaddr_o;
    logic [DWIDTH-1:0] rddata_i;
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              sop_o;
    logic              eop_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;

    // Controller side.
    modport slave (
        input  start_i, abort_i, len_i, rddata_i, ready_i,
        output rden_o, rdaddr_o, data_o, valid_o, sop_o, eop_o, busy_o, done_o
    );

    // Requester / RAM / stream-sink side.
    modport master (
        output start_i, abort_i, len_i, rddata_i, ready_i,
        input  rden_o, rdaddr_o, data_o, valid_o, sop_o, eop_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_rd_buf.sv
// Small synchronous FIFO; entry 0 is the registered head presented downstream.
module mem_rd_buf #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           not_empty,
    output logic [$clog2(DEPTH+1)-1:0]     usedw
);
    localparam int unsigned UW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [UW-1:0]    count;
    logic             do_pop;
    logic [UW-1:0]    wr_idx;

    // Write slot accounts for a same-cycle pop shifting everything down.
    always_comb begin
        do_pop = pop && (count != '0);
        wr_idx = count - UW'(do_pop);
    end

    // Shift-down storage: pop moves every entry one slot toward the head.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wr_idx == UW'(i)) begin
                        mem[i] <= push_data;
                    end
                end
            end
            count <= count + UW'(push) - UW'(do_pop);
        end
    end

    assign head_data = mem[0];
    assign not_empty = (count != '0);
    assign usedw     = count;

endmodule

// File: rtl/mem_rd_ctrl.sv
// Reads len words from RAM address 0 upward and emits them as a
// valid/ready packet; reads are credit-limited against the output buffer.
module mem_rd_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH     = 4,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          srst_i,
    mem_rd_ctrl_if.slave  bus
);
    localparam int unsigned BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int unsigned CW        = $clog2(BUF_DEPTH + 1);

    localparam logic [AWIDTH:0]   ONE_L     = 1;
    localparam logic [AWIDTH-1:0] ONE_A     = 1;
    localparam logic [CW:0]       CREDITS   = (CW+1)'(BUF_DEPTH);

    state_t              state_q, state_d;
    logic [AWIDTH:0]     len_q;
    logic [AWIDTH:0]     issued_q;
    logic [AWIDTH:0]     pushed_q;
    logic [AWIDTH-1:0]   rdaddr_q;
    logic [CW-1:0]       inflight_q;
    logic [RD_LATENCY-1:0] tag_q;
    logic                done_q;

    logic                rden;
    logic                busy;
    logic                credit_ok;
    logic                last_issue;
    logic                arrival;
    logic                pop;
    logic [DWIDTH+1:0]   head;
    logic                head_valid;
    logic [CW-1:0]       usedw;
    logic                sop_w;
    logic                eop_w;

    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, usedw}) < CREDITS;
    assign last_issue = (issued_q == len_q - ONE_L);
    assign arrival    = tag_q[RD_LATENCY-1];
    assign pop        = head_valid && bus.ready_i;
    assign sop_w      = (pushed_q == '0);
    assign eop_w      = (pushed_q == len_q - ONE_L);

    // State register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus read-enable and busy outputs.
    always_comb begin
        state_d = state_q;
        rden    = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && (bus.len_i != '0)) begin
                    state_d = READ;
                end
            end
            READ: begin
                rden = credit_ok;
                if (credit_ok && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[DWIDTH]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort_i) begin
            state_d = IDLE;
        end
    end

    // Counters, in-flight tag delay line and done pulse.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            len_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            rdaddr_q   <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
            done_q     <= 1'b0;
        end else if (bus.abort_i) begin
            issued_q   <= '0;
            pushed_q   <= '0;
            rdaddr_q   <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            tag_q[0] <= rden;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            inflight_q <= inflight_q + CW'(rden) - CW'(arrival);
            if (arrival) begin
                pushed_q <= pushed_q + ONE_L;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.len_i != '0) begin
                            len_q    <= bus.len_i;
                            issued_q <= '0;
                            pushed_q <= '0;
                            rdaddr_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rden) begin
                        issued_q <= issued_q + ONE_L;
                        // Hold the final address so a full-size packet never wraps.
                        if (!last_issue) begin
                            rdaddr_q <= rdaddr_q + ONE_A;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[DWIDTH]) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_rd_buf #(
        .WIDTH (DWIDTH + 2),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk_i),
        .rst       (srst_i),
        .flush     (bus.abort_i),
        .push      (arrival && !bus.abort_i),
        .push_data ({sop_w, eop_w, bus.rddata_i}),
        .pop       (pop),
        .head_data (head),
        .not_empty (head_valid),
        .usedw     (usedw)
    );

    assign bus.rden_o   = rden;
    assign bus.rdaddr_o = rdaddr_q;
    assign bus.data_o   = head[DWIDTH-1:0];
    assign bus.valid_o  = head_valid;
    assign bus.sop_o    = head_valid && head[DWIDTH+1];
    assign bus.eop_o    = head_valid && head[DWIDTH];
    assign bus.busy_o   = busy;
    assign bus.done_o   = done_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Scoreboard bench for mem_rd_ctrl with a registered-read RAM model.
module tb_mem_rd_ctrl;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = 2;

    logic clk  = 1'b0;
    logic srst = 1'b1;

    mem_rd_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_rd_ctrl #(
        .AWIDTH     (AW),
        .DWIDTH     (DW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // RAM model: content 0x10+addr, data valid LAT cycles after rden.
    logic [DW-1:0] ram  [16];
    logic [DW-1:0] pipe [LAT];
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
    end
    always @(posedge clk) begin
        pipe[0] <= bus.rden_o ? ram[bus.rdaddr_o] : 8'hEE;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rddata_i = pipe[LAT-1];

    int errors = 0;
    int checks = 0;
    logic [DW+1:0] exp_q [$];
    int exp_addr = 0;
    int pkt_reads = 0;
    int pkt_xfer = 0;
    int rd_total = 0;
    int done_cnt = 0;
    logic done_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; accepted packets get their words queued.
    task automatic start_pkt(input int len, input bit accept);
        bus.start_i = 1'b1;
        bus.len_i   = 5'(len);
        if (accept) begin
            exp_addr  = 0;
            pkt_reads = 0;
            pkt_xfer  = 0;
            for (int i = 0; i < len; i++)
                exp_q.push_back({(i == 0), (i == len - 1), 8'(8'h10 + i)});
        end
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge clk);
            if (!bus.busy_o && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rden"},  32'(bus.rden_o),   0);
        check({tag, "_valid"}, 32'(bus.valid_o),  0);
        check({tag, "_sop"},   32'(bus.sop_o),    0);
        check({tag, "_eop"},   32'(bus.eop_o),    0);
        check({tag, "_busy"},  32'(bus.busy_o),   0);
        check({tag, "_done"},  32'(bus.done_o),   0);
        check({tag, "_addr"},  32'(bus.rdaddr_o), 0);
        check({tag, "_data"},  32'(bus.data_o),   0);
    endtask

    // Output monitor: pops the scoreboard, tracks reads, done and credit bound.
    always @(negedge clk) begin
        logic [DW+1:0] w;
        check("done", 32'(bus.done_o), 32'(done_exp));
        if (bus.done_o) done_cnt++;
        done_exp = 1'b0;
        if (bus.valid_o && bus.ready_i) begin
            pkt_xfer++;
            if (exp_q.size() == 0) begin
                check("extra_word", 32'({bus.sop_o, bus.eop_o, bus.data_o}), 32'h3FF);
            end else begin
                w = exp_q.pop_front();
                check("word", 32'({bus.sop_o, bus.eop_o, bus.data_o}), 32'(w));
            end
            if (bus.eop_o) done_exp = 1'b1;
        end
        if (bus.start_i && !bus.busy_o && bus.len_i == '0) done_exp = 1'b1;
        if (bus.rden_o) begin
            check("rdaddr", 32'(bus.rdaddr_o), 32'(exp_addr));
            exp_addr++;
            pkt_reads++;
            rd_total++;
        end
        if (bus.busy_o) check("credit", 32'((pkt_reads - pkt_xfer) <= 4), 1);
        if (bus.abort_i || srst) begin
            exp_q.delete();
            done_exp  = 1'b0;
            pkt_reads = 0;
            pkt_xfer  = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int rd_before;
        int done_before;
        bit reached;
        logic [DW+1:0] snap;

        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.len_i   = '0;
        bus.ready_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        srst = 1'b0;
        bus.ready_i = 1'b1;
        tick();

        // Basic packet with latency/timing checks.
        d0 = done_cnt;
        start_pkt(5, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("basic_rden_t", 32'(bus.rden_o), 32'(k <= 5));
            check("basic_valid_t", 32'(bus.valid_o), 32'(k >= 4));
        end
        wait_idle(40);
        check("basic_done_cnt", 32'(done_cnt - d0), 1);

        // Zero length: no reads, no words, done next cycle.
        d0 = done_cnt;
        rd_before = rd_total;
        start_pkt(0, 1'b1);
        repeat (4) @(negedge clk);
        check("zero_no_reads", 32'(rd_total - rd_before), 0);
        check("zero_done_cnt", 32'(done_cnt - d0), 1);
        tick();

        // Full length: addresses 0..15 once each.
        d0 = done_cnt;
        start_pkt(16, 1'b1);
        wait_idle(80);
        check("full_reads", 32'(pkt_reads), 16);
        check("full_done_cnt", 32'(done_cnt - d0), 1);

        // Backpressure: random ready, then a long stall.
        d0 = done_cnt;
        start_pkt(8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.ready_i = 1'b0;
        for (int h = 1; h <= 10; h++) begin
            @(negedge clk);
            if (h == 3) snap = {bus.sop_o, bus.eop_o, bus.data_o};
            if (h == 10) begin
                check("bp_hold_valid", 32'(bus.valid_o), 1);
                check("bp_hold_data", 32'({bus.sop_o, bus.eop_o, bus.data_o}), 32'(snap));
                check("bp_rden_stall", 32'(bus.rden_o), 0);
            end
        end
        tick();
        bus.ready_i = 1'b1;
        wait_idle(80);
        check("bp_reads", 32'(pkt_reads), 8);
        check("bp_done_cnt", 32'(done_cnt - d0), 1);

        // Start while busy is ignored.
        d0 = done_cnt;
        start_pkt(6, 1'b1);
        tick();
        start_pkt(3, 1'b0);
        wait_idle(60);
        check("busy_start_words", 32'(pkt_xfer), 6);
        check("busy_start_done_cnt", 32'(done_cnt - d0), 1);

        // Abort after three words with reads still in flight.
        d0 = done_cnt;
        start_pkt(8, 1'b1);
        reached = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pkt_xfer >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        check("abort_reach3", 32'(reached), 1);
        tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(bus.valid_o), 0);
        check("abort_busy", 32'(bus.busy_o), 0);
        repeat (6) tick();
        check("abort_no_done", 32'(done_cnt - d0), 0);
        start_pkt(2, 1'b1);
        wait_idle(40);
        check("after_abort_words", 32'(pkt_xfer), 2);

        // Synchronous reset during DRAIN.
        start_pkt(16, 1'b1);
        reached = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (pkt_reads >= 16) begin
                reached = 1'b1;
                break;
            end
        end
        check("drain_reach", 32'(reached), 1);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        tick();
        d0 = done_cnt;
        start_pkt(3, 1'b1);
        wait_idle(40);
        check("after_reset_words", 32'(pkt_xfer), 3);
        check("after_reset_done_cnt", 32'(done_cnt - d0), 1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_rd_ctrl.md
Name: mem_rd_ctrl

Overview:
Read-side counterpart of the write-address counter that fills the lab's single-port-write / registered-read RAM. On a start pulse it reads back a given number of words from address 0 upward and emits them as a valid/ready packet stream with sop/eop markers. Read issue is credit-limited against a small output buffer, so downstream backpressure never loses or duplicates a word, whatever the RAM read latency.

Parameters:
AWIDTH, 4, RAM address width; the RAM holds 2**AWIDTH words
DWIDTH, 8, RAM data width
RD_LATENCY, 2, RAM read latency in cycles (legal values 1..3); `rddata_i` is valid RD_LATENCY cycles after `rden_o`

Ports:
clk_i  input  1  clock; all logic on rising edge
srst_i  input  1  synchronous reset, active-high
start_i  input  1  one-cycle request to read back a packet; honoured only in IDLE
abort_i  input  1  cancel the current packet; return to IDLE, no done pulse
len_i  input  AWIDTH+1  word count 0..2**AWIDTH; sampled when start_i is honoured
rden_o  output  1  RAM read enable
rdaddr_o  output  AWIDTH  RAM read address
rddata_i  input  DWIDTH  RAM read data
data_o  output  DWIDTH  stream data
valid_o  output  1  stream valid
sop_o  output  1  first word of packet (qualified by valid_o)
eop_o  output  1  last word of packet (qualified by valid_o)
ready_i  input  1  downstream ready; transfer = valid_o & ready_i
busy_o  output  1  high in every state other than IDLE
done_o  output  1  one-cycle pulse at packet completion

Behaviour:
- Reset: state IDLE; rden_o, valid_o, sop_o, eop_o, busy_o and done_o are 0; rdaddr_o is 0; data_o is 0; buffer is empty; in-flight count is 0.
- BUF_DEPTH = RD_LATENCY+2. The buffer is a registered FIFO.
- Credit rule: a read may issue only when inflight + occupancy < BUF_DEPTH. Neither count is reduced by a same-cycle pop or arrival.
- FSM states: IDLE, READ, DRAIN.
- IDLE to READ: start_i=1 with len_i>0. On that edge, latch len, set rdaddr_o=0 and issued=0.
- IDLE with start_i=1 and len_i=0: stay in IDLE; done_o pulses on the next cycle; no stream output.
- READ: rden_o = credit_ok, driven combinationally from registered counts. Each cycle with rden_o high, rdaddr_o increments on the edge and issued increments.
- READ to DRAIN: when the last read issues (issued == len-1 with rden_o high).
- Address range: rdaddr_o never wraps. For len = 2**AWIDTH the last address is all ones, and no further rden_o is issued.
- DRAIN: no reads; wait until inflight == 0 and the buffer is empty with the eop word transferred.
- DRAIN to IDLE: on the edge where eop is transferred. done_o is high in the following cycle.
- Data path: a delay line of length RD_LATENCY carries the rden tag. A tagged rddata_i is written into the buffer at the end of cycle issue+RD_LATENCY. valid_o rises in the next cycle, so first-word latency from start_i is RD_LATENCY+2 cycles.
- Output markers: sop_o is set on the first word pushed for the packet and eop_o on the word whose index is len-1. Both are stored alongside the data in the buffer.
- Stream rules: while valid_o=1 and ready_i=0, data_o, sop_o and eop_o are held stable. With ready_i held high, the block sustains one word per cycle.
- start_i while busy: ignored; len_i is not resampled.
- abort_i: takes priority over start_i. From any state, on the next edge: IDLE, buffer flushed, in-flight tags cleared (late RAM data discarded), valid_o=0, no done pulse.
- srst_i: takes priority over everything. Mid-packet, it gives the same outputs as power-on reset.

Decomposition:
- Package mem_ctrl_pkg: the state enum (IDLE, READ, DRAIN) and a localparam function computing BUF_DEPTH from RD_LATENCY. The write-side counter may reuse this package.
- One sub-module: mem_rd_buf, a parameterised synchronous FIFO (DWIDTH+2 bits wide, BUF_DEPTH deep, registered outputs, usedw output for the credit check). The FSM, counters and latency delay line stay in mem_rd_ctrl.

Test Plan:
- Basic packet: RAM preloaded with 0x10..0x1F, RD_LATENCY=2, ready_i=1, start with len=5 → rdaddr_o 0..4 on 5 consecutive cycles. Data 0x10..0x14 appears on 5 consecutive valid cycles, starting 4 cycles after start_i. sop on 0x10, eop on 0x14, done one cycle after the eop transfer.
- Zero and full length: len=0 → no rden_o, no valid_o, done pulse on the next cycle. len=16 → addresses 0..15 each read exactly once, eop on 0x1F, no read after address 15.
- Backpressure: len=8 with ready_i random at 50%, then held low for 10 cycles → outstanding reads plus buffered words never exceed 4 and rden_o stops. Output sequence is exactly 0x10..0x17 in order with no duplicates or gaps.
- Start while busy: a second start_i with len=3 during a len=6 packet → ignored; exactly 6 words and one done pulse.
- Abort mid-packet: abort_i asserted after 3 words transferred with reads in flight → valid_o=0 next cycle, busy_o=0, no done. A following len=2 packet outputs 0x10 and 0x11 with no stale data.
- Reset mid-packet: srst_i asserted during DRAIN → all outputs at reset values next cycle; a subsequent start works normally.
